data_memory_io_ctrl: RTL and testbench
======================================

Name: data_memory_io_ctrl

Overview:
- Parametrised successor to the single-channel data memory / IO block in the RISC-V datapath; sits on the core's load/store path.
- Byte-addressed data RAM with RV32 sub-word loads and stores (byte/half/word, signed/unsigned) and a registered 1-cycle read.
- NUM_IO memory-mapped IO channels, each with a synchronised input, change detection, and a registered output with a write strobe.
- Detects misaligned and out-of-range accesses.

Parameters:
DEPTH_BYTES, 1024, RAM size in bytes (power of 2, >=4); RAM occupies 0 .. DEPTH_BYTES-1
NUM_IO, 4, number of IO channels (1..8)
IO_BASE, 32'h7FFFFFF0, address of channel 0; channel i at IO_BASE+4*i (default puts channel 3 at 32'h7FFFFFFC)
STATUS_ADDR, 32'h7FFFFFEC, read-only IO status word

Ports:
CLK  in  1  clock, all state on posedge
nRESET  in  1  synchronous, active-low reset
A  in  32  byte address
WD  in  32  store data, right-aligned
WE  in  1  store request
RE  in  1  load request
Size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
Unsigned  in  1  1 = zero-extend load, 0 = sign-extend
RD  out  32  load data, registered
RValid  out  1  one-cycle pulse, RD valid
MisalignErr  out  1  one-cycle pulse
RangeErr  out  1  one-cycle pulse
CPUIn  in  32*NUM_IO  asynchronous channel inputs, channel i at [32i+31:32i]
CPUOut  out  32*NUM_IO  registered channel outputs
OutStrobe  out  NUM_IO  one-cycle pulse per channel write

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-low on nRESET, sampled at posedge CLK.
- Reset values: RD=0, RValid=0, MisalignErr=0, RangeErr=0, CPUOut=0, OutStrobe=0, sync/history flops=0, InNew=0. RAM contents are not reset.
- Reset mid-access: the request in that cycle is dropped, so RValid is 0 in the next cycle.
- Decode, in priority order:
  - Channel i: A == IO_BASE+4*i.
  - Status: A == STATUS_ADDR.
  - RAM: A < DEPTH_BYTES.
  - Anything else is out of range.
- Alignment: half requires A[0]=0; word requires A[1:0]=0; Size=11 is always misaligned.
- IO and status accesses must be word size; any other size there is misaligned.
- Error checks run only when WE or RE is high:
  - Misaligned takes precedence over out of range.
  - On an error: no state change; RD=0 and RValid=1 if RE was high; the matching error flag pulses in the cycle after the request.
- RAM store: writes bytes A .. A+size-1 from WD[7:0] upward (little-endian). Other bytes are unchanged.
- RAM load:
  - Sampled at posedge; RD and RValid update on that edge (1-cycle latency).
  - Byte/half are extended per Unsigned.
  - RD holds its value until the next load completes.
- WE and RE in the same cycle: read-before-write. The load returns the pre-store contents; the store still commits.
- Channel write: CPUOut[i] <= WD; OutStrobe[i]=1 for exactly the cycle in which the new value first appears.
- Channel read: returns the synchronised CPUIn[i] (2-flop synchroniser, stage-2 value).
- Change detection: a third history flop per channel. InNew[i] is set when stage2 != history.
- Status read returns {zero-pad, InNew[NUM_IO-1:0]}. Status writes are ignored with no error.
- InNew[i] clears when channel i is read. If a set and a clear occur in the same cycle, set wins.
- CPUIn propagation: a change reaches a channel read 2 cycles after it is applied.

Test Plan:
- Reset with nRESET=0 for 2 cycles while WE=1 to channel 0 -> CPUOut=0, OutStrobe=0, RValid=0 throughout; after release all outputs are 0.
- SW 32'h8001FF7F to A=0x10, then LB 0x10 signed -> RD=32'h0000007F; LB 0x11 signed -> 32'hFFFFFFFF; LHU 0x12 -> 32'h00008001; LH 0x12 -> 32'hFFFF8001. Each RValid pulses 1 cycle after RE.
- SB 8'hAA to 0x13 with WE=RE=1 same cycle, LW 0x10 the same cycle -> RD=32'h8001FF7F (old contents); next LW 0x10 -> 32'hAA01FF7F.
- SW to 32'h7FFFFFFC with WD=32'h1234 -> CPUOut ch3 = 32'h1234 and OutStrobe=4'b1000 for one cycle; other channels unchanged.
- Change CPUIn ch1 to 32'h5 -> status read shows bit1=1; read ch1 returns 5 and clears the bit; a subsequent status read shows bit1=0.
- LW 0x11 -> MisalignErr pulse, RD=0, RValid=1. SW 0x400 (DEPTH_BYTES=1024) -> RangeErr pulse, RAM unchanged. LH to IO_BASE -> MisalignErr, CPUOut unchanged.

Source files
------------

// File: rtl/data_memory_io_ctrl.sv
// Data RAM with RV32 sub-word access plus memory-mapped IO channels.
// Registered 1-cycle loads; misaligned and out-of-range flags.
module data_memory_io_ctrl #(
  parameter int          DEPTH_BYTES = 1024,
  parameter int          NUM_IO      = 4,
  parameter logic [31:0] IO_BASE     = 32'h7FFFFFF0,
  parameter logic [31:0] STATUS_ADDR = 32'h7FFFFFEC
) (
  input  logic                  CLK,
  input  logic                  nRESET,
  input  logic [31:0]           A,
  input  logic [31:0]           WD,
  input  logic                  WE,
  input  logic                  RE,
  input  logic [1:0]            Size,
  input  logic                  Unsigned,
  output logic [31:0]           RD,
  output logic                  RValid,
  output logic                  MisalignErr,
  output logic                  RangeErr,
  input  logic [32*NUM_IO-1:0]  CPUIn,
  output logic [32*NUM_IO-1:0]  CPUOut,
  output logic [NUM_IO-1:0]     OutStrobe
);

  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0] mem [DEPTH_BYTES];

  logic [NUM_IO-1:0][31:0] s1, s2, hist, out_q;
  logic [NUM_IO-1:0]       in_new, chg, rd_clr, io_hit;
  logic [31:0]             io_rd, ld, rdata;
  logic [7:0]              rb [4];
  logic [AW-1:0]           addr;
  logic                    io_any, st_hit, ram_hit;
  logic                    req, mis, mis_err, rng_err;
  logic                    ok, re_ok, we_ok, we_ram;

  assign addr   = A[AW-1:0];
  assign CPUOut = out_q;

  always_comb begin
    io_hit = '0;
    io_rd  = '0;
    chg    = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      io_hit[i] = (A == IO_BASE + 32'(4 * i));
      if (io_hit[i]) io_rd = io_rd | s2[i];
      chg[i] = (s2[i] != hist[i]);
    end
  end

  // Channel match outranks status, status outranks RAM
  always_comb begin
    io_any  = |io_hit;
    st_hit  = !io_any && (A == STATUS_ADDR);
    ram_hit = !io_any && !st_hit && (A < 32'(DEPTH_BYTES));
    req     = WE | RE;
    unique case (Size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = A[0];
      2'b10:   mis = |A[1:0];
      default: mis = 1'b1;
    endcase
    if ((io_any || st_hit) && Size != 2'b10) mis = 1'b1;
    mis_err = req && mis;
    rng_err = req && !mis && !(io_any || st_hit || ram_hit);
    ok      = !mis && (io_any || st_hit || ram_hit);
    re_ok   = RE && ok;
    we_ok   = WE && ok;
    we_ram  = we_ok && ram_hit;
    rd_clr  = re_ok ? io_hit : '0;
  end

  always_comb begin
    for (int k = 0; k < 4; k++) rb[k] = mem[addr + AW'(k)];
    unique case (Size)
      2'b00: ld = Unsigned ? {24'h0, rb[0]}
                           : {{24{rb[0][7]}}, rb[0]};
      2'b01: ld = Unsigned ? {16'h0, rb[1], rb[0]}
                           : {{16{rb[1][7]}}, rb[1], rb[0]};
      default: ld = {rb[3], rb[2], rb[1], rb[0]};
    endcase
  end

  always_comb begin
    unique case (1'b1)
      io_any:  rdata = io_rd;
      st_hit:  rdata = 32'(in_new);
      default: rdata = ld;
    endcase
  end

  // Read-before-write: the load path samples mem before this edge commits
  always_ff @(posedge CLK) begin
    if (nRESET && we_ram) begin
      mem[addr] <= WD[7:0];
      if (Size != 2'b00) mem[addr + AW'(1)] <= WD[15:8];
      if (Size == 2'b10) begin
        mem[addr + AW'(2)] <= WD[23:16];
        mem[addr + AW'(3)] <= WD[31:24];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      RD          <= '0;
      RValid      <= 1'b0;
      MisalignErr <= 1'b0;
      RangeErr    <= 1'b0;
      OutStrobe   <= '0;
      out_q       <= '0;
      s1          <= '0;
      s2          <= '0;
      hist        <= '0;
      in_new      <= '0;
    end else begin
      RValid      <= RE;
      MisalignErr <= mis_err;
      RangeErr    <= rng_err;
      if (RE) RD  <= re_ok ? rdata : '0;
      OutStrobe   <= we_ok ? io_hit : '0;
      for (int i = 0; i < NUM_IO; i++)
        if (we_ok && io_hit[i]) out_q[i] <= WD;
      s1     <= CPUIn;
      s2     <= s1;
      hist   <= s2;
      in_new <= (in_new & ~rd_clr) | chg;
    end
  end

endmodule

// File: tb/tb_data_memory_io_ctrl.sv
// Directed bench for data_memory_io_ctrl.
// Load results go through an expected-value queue.
module tb_data_memory_io_ctrl;

  localparam logic [31:0] IOB = 32'h7FFFFFF0;
  localparam logic [31:0] STA = 32'h7FFFFFEC;

  logic         CLK = 1'b0;
  logic         nRESET;
  logic [31:0]  A, WD;
  logic         WE, RE, Unsigned;
  logic [1:0]   Size;
  logic [31:0]  RD;
  logic         RValid, MisalignErr, RangeErr;
  logic [127:0] CPUIn, CPUOut;
  logic [3:0]   OutStrobe;

  int tests = 0;
  int fails = 0;
  logic [31:0] q [$];

  data_memory_io_ctrl dut (
    .CLK(CLK), .nRESET(nRESET), .A(A), .WD(WD), .WE(WE), .RE(RE),
    .Size(Size), .Unsigned(Unsigned), .RD(RD), .RValid(RValid),
    .MisalignErr(MisalignErr), .RangeErr(RangeErr),
    .CPUIn(CPUIn), .CPUOut(CPUOut), .OutStrobe(OutStrobe)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic acc(input string tag, input logic [31:0] a,
                     input logic [31:0] wd, input logic we,
                     input logic re, input logic [1:0] sz,
                     input logic uns, input logic [31:0] exp_rd,
                     input logic em, input logic er);
    logic [31:0] e;
    A = a; WD = wd; WE = we; RE = re; Size = sz; Unsigned = uns;
    if (re) q.push_back(exp_rd);
    step();
    WE = 1'b0; RE = 1'b0;
    chk({tag, ".rvalid"}, 128'(RValid), 128'(re));
    if (RValid) begin
      if (q.size() == 0) chk({tag, ".q_empty"}, 128'(1), 128'(0));
      else begin
        e = q.pop_front();
        chk({tag, ".rd"}, 128'(RD), 128'(e));
      end
    end
    chk({tag, ".mis"}, 128'(MisalignErr), 128'(em));
    chk({tag, ".rng"}, 128'(RangeErr), 128'(er));
  endtask

  initial begin
    nRESET = 1'b0; CPUIn = '0;
    A = IOB; WD = 32'hDEAD; WE = 1'b1; RE = 1'b0;
    Size = 2'b10; Unsigned = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst.cpuout", CPUOut, 128'h0);
      chk("rst.strobe", 128'(OutStrobe), 128'h0);
      chk("rst.rvalid", 128'(RValid), 128'h0);
    end
    nRESET = 1'b1; WE = 1'b0;
    step();
    chk("post.rd", 128'(RD), 128'h0);
    chk("post.flags", 128'({RValid, MisalignErr, RangeErr}), 128'h0);
    chk("post.cpuout", CPUOut, 128'h0);
    chk("post.strobe", 128'(OutStrobe), 128'h0);

    acc("sw10", 32'h10, 32'h8001FF7F, 1, 0, 2'b10, 0, 0, 0, 0);
    acc("lb10", 32'h10, 0, 0, 1, 2'b00, 0, 32'h0000007F, 0, 0);
    acc("lb11", 32'h11, 0, 0, 1, 2'b00, 0, 32'hFFFFFFFF, 0, 0);
    acc("lhu12", 32'h12, 0, 0, 1, 2'b01, 1, 32'h00008001, 0, 0);
    acc("lh12", 32'h12, 0, 0, 1, 2'b01, 0, 32'hFFFF8001, 0, 0);
    step();
    chk("rvalid.pulse", 128'(RValid), 128'h0);

    acc("sb13rw", 32'h13, 32'hAA, 1, 1, 2'b00, 1, 32'h00000080, 0, 0);
    acc("lw10new", 32'h10, 0, 0, 1, 2'b10, 0, 32'hAA01FF7F, 0, 0);
    acc("swlw10", 32'h10, 32'h11223344, 1, 1, 2'b10, 0,
        32'hAA01FF7F, 0, 0);
    acc("lw10b", 32'h10, 0, 0, 1, 2'b10, 0, 32'h11223344, 0, 0);

    acc("sw_ch3", 32'h7FFFFFFC, 32'h1234, 1, 0, 2'b10, 0, 0, 0, 0);
    chk("ch3.out", CPUOut, {32'h1234, 96'h0});
    chk("ch3.strobe", 128'(OutStrobe), 128'h8);
    step();
    chk("ch3.strobe_off", 128'(OutStrobe), 128'h0);
    chk("ch3.hold", CPUOut, {32'h1234, 96'h0});

    CPUIn[63:32] = 32'h5;
    step(); step(); step();
    acc("st1", STA, 0, 0, 1, 2'b10, 0, 32'h2, 0, 0);
    acc("rd_ch1", IOB + 32'h4, 0, 0, 1, 2'b10, 0, 32'h5, 0, 0);
    acc("st0", STA, 0, 0, 1, 2'b10, 0, 32'h0, 0, 0);
    acc("st_wr", STA, 32'hF, 1, 0, 2'b10, 0, 0, 0, 0);
    acc("rd_ch2", IOB + 32'h8, 0, 0, 1, 2'b10, 0, 32'h0, 0, 0);

    acc("lw11", 32'h11, 0, 0, 1, 2'b10, 0, 32'h0, 1, 0);
    acc("sz11", 32'h10, 0, 0, 1, 2'b11, 0, 32'h0, 1, 0);
    acc("sw3fc", 32'h3FC, 32'hCAFEF00D, 1, 0, 2'b10, 0, 0, 0, 0);
    acc("sw400", 32'h400, 32'hFFFFFFFF, 1, 0, 2'b10, 0, 0, 0, 1);
    acc("lw3fc", 32'h3FC, 0, 0, 1, 2'b10, 0, 32'hCAFEF00D, 0, 0);
    acc("lw400", 32'h400, 0, 0, 1, 2'b10, 0, 32'h0, 0, 1);
    acc("mis_rng", 32'h401, 0, 0, 1, 2'b01, 0, 32'h0, 1, 0);
    acc("lh_io", IOB, 32'hBEEF, 1, 0, 2'b01, 0, 0, 1, 0);
    chk("lh_io.cpuout", CPUOut, {32'h1234, 96'h0});
    chk("lh_io.strobe", 128'(OutStrobe), 128'h0);
    step();
    chk("err.pulse", 128'({MisalignErr, RangeErr}), 128'h0);

    A = 32'h10; RE = 1'b1; Size = 2'b10; nRESET = 1'b0;
    step();
    chk("rst_mid.rvalid", 128'(RValid), 128'h0);
    chk("rst_mid.rd", 128'(RD), 128'h0);
    nRESET = 1'b1; RE = 1'b0;
    step();
    chk("rst_mid.rvalid2", 128'(RValid), 128'h0);
    chk("q.drained", 128'(q.size()), 128'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
